// File: rtl/if_reg_if.sv
// if_reg_if: instruction fetch bus between the IF stage (master) and the bus interface (slave).
interface if_reg_if;
    logic [29:0] fetch_addr;
    logic        fetch_as_;
    logic        fetch_rw;
    logic [31:0] insn;
    modport master (output fetch_addr, fetch_as_, fetch_rw, input insn);
    modport slave  (input fetch_addr, fetch_as_, fetch_rw, output insn);
endinterface

// File: rtl/if_reg.sv
// if_reg: IF-stage PC sequencer and IF/ID pipeline register with stall-safe redirect buffering.
// Optional perf counters enabled by defining IF_PERF_CNT_EN.
module if_reg #(
    parameter logic [29:0] RESET_VECTOR = 30'h0,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] new_pc,
    input  logic        br_taken,
    input  logic [29:0] br_addr,
    if_reg_if.master    bus,
    output logic [29:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
);
    localparam logic READ = 1'b1;
    typedef enum logic {RUN, HOLD_REDIR} state_e;
    state_e      state_q, state_d;
    logic [29:0] fetch_pc_q, fetch_pc_d, if_pc_q, if_pc_d, pend_addr_q, pend_addr_d;
    logic [31:0] if_insn_q, if_insn_d;
    logic        fetch_as_q, fetch_as_d, if_en_q, if_en_d, pend_vld_q, pend_vld_d;
    logic        hold, adv;
    // The cycle before the strobe first asserts holds like a stall: nothing fetched yet.
    always_comb begin
        hold        = stall | fetch_as_q;
        adv         = !flush && !hold;
        fetch_as_d  = 1'b0;
        fetch_pc_d  = fetch_pc_q;
        if_pc_d     = if_pc_q;
        if_insn_d   = if_insn_q;
        if_en_d     = if_en_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        state_d     = state_q;
        if (flush) begin
            fetch_pc_d = new_pc;
            if_pc_d    = new_pc;
            if_insn_d  = NOP_INSN;
            if_en_d    = 1'b0;
            pend_vld_d = 1'b0;
            state_d    = RUN;
        end else if (hold) begin
            if (br_taken) begin
                pend_addr_d = br_addr;
                pend_vld_d  = 1'b1;
                state_d     = HOLD_REDIR;
            end
        end else begin
            if_insn_d  = bus.insn;
            if_pc_d    = fetch_pc_q;
            if_en_d    = 1'b1;
            fetch_pc_d = br_taken ? br_addr : pend_vld_q ? pend_addr_q : fetch_pc_q + 30'd1;
            pend_vld_d = 1'b0;
            state_d    = RUN;
        end
    end
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fetch_pc_q  <= RESET_VECTOR;
            fetch_as_q  <= 1'b1;
            if_pc_q     <= RESET_VECTOR;
            if_insn_q   <= NOP_INSN;
            if_en_q     <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            state_q     <= RUN;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            fetch_as_q  <= fetch_as_d;
            if_pc_q     <= if_pc_d;
            if_insn_q   <= if_insn_d;
            if_en_q     <= if_en_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            state_q     <= state_d;
        end
    end
    assign bus.fetch_addr = fetch_pc_q;
    assign bus.fetch_as_  = fetch_as_q;
    assign bus.fetch_rw   = READ;
    assign if_pc          = if_pc_q;
    assign if_insn        = if_insn_q;
    assign if_en          = if_en_q;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;
    always_comb begin
        perf_fetch_d = (adv && ~&perf_fetch_q) ? perf_fetch_q + 32'd1 : perf_fetch_q;
        perf_stall_d = (stall && !flush && ~&perf_stall_q) ? perf_stall_q + 32'd1 : perf_stall_q;
    end
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end
    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`else
    logic unused_adv;
    assign unused_adv = adv;
    assign perf_fetch = 32'h0;
    assign perf_stall = 32'h0;
`endif
endmodule

// File: tb/tb_if_reg.sv
// tb_if_reg: randomized and directed checks of if_reg against a spec-level reference model.
module tb_if_reg;
    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
    logic [29:0] new_pc = '0, br_addr = '0;
    logic [31:0] insn = '0;
    logic [29:0] if_pc;
    logic [31:0] if_insn, perf_fetch, perf_stall;
    logic        if_en;
    int          n_chk = 0, n_err = 0;
    // reference model state
    logic [29:0] m_pc, m_ipc, m_pa;
    logic [31:0] m_insn, m_pf, m_ps;
    bit          m_en, m_as, m_pv;
    if_reg_if bus ();
    assign bus.insn = insn;
    if_reg dut (
        .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_taken(br_taken), .br_addr(br_addr), .bus(bus), .if_pc(if_pc),
        .if_insn(if_insn), .if_en(if_en), .perf_fetch(perf_fetch), .perf_stall(perf_stall)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_pc = '0; m_ipc = '0; m_pa = '0; m_insn = NOP;
        m_en = 0; m_as = 1; m_pv = 0; m_pf = 0; m_ps = 0;
    endtask
    task automatic check_all(input string tag);
        check({tag, ".addr"}, {2'b0, bus.fetch_addr}, {2'b0, m_pc});
        check({tag, ".as_"}, {31'b0, bus.fetch_as_}, {31'b0, m_as});
        check({tag, ".rw"}, {31'b0, bus.fetch_rw}, 32'd1);
        check({tag, ".if_pc"}, {2'b0, if_pc}, {2'b0, m_ipc});
        check({tag, ".if_insn"}, if_insn, m_insn);
        check({tag, ".if_en"}, {31'b0, if_en}, {31'b0, m_en});
        check({tag, ".pf"}, perf_fetch, PERF_ON ? m_pf : 32'h0);
        check({tag, ".ps"}, perf_stall, PERF_ON ? m_ps : 32'h0);
    endtask
    // One clock: model applies flush > stall > advance with the inputs of this edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (stall && !flush && m_ps != 32'hFFFF_FFFF) m_ps++;
        if (flush) begin
            m_pc = new_pc; m_ipc = new_pc; m_insn = NOP; m_en = 0; m_pv = 0;
        end else if (stall || m_as) begin
            if (br_taken) begin m_pa = br_addr; m_pv = 1; end
        end else begin
            m_insn = insn; m_ipc = m_pc; m_en = 1;
            if (br_taken) m_pc = br_addr;
            else if (m_pv) m_pc = m_pa;
            else m_pc = m_pc + 30'd1;
            m_pv = 0;
            if (m_pf != 32'hFFFF_FFFF) m_pf++;
        end
        m_as = 0;
        @(negedge clk);
        check_all(tag);
    endtask
    task automatic set_in(input bit s, input bit f, input logic [29:0] np, input bit b, input logic [29:0] ba);
        stall = s; flush = f; new_pc = np; br_taken = b; br_addr = ba;
    endtask
    task automatic do_reset();
        reset_ = 0;
        set_in(0, 0, '0, 0, '0);
        model_reset();
        @(negedge clk);
        check_all("reset");
        reset_ = 1;
    endtask
    initial begin
        model_reset();
        // T1
        insn = 32'hA0A0_0001;
        do_reset();
        step("t1a");
        check("t1_as", {31'b0, bus.fetch_as_}, 32'd0);
        step("t1b");
        check("t1_pc", {2'b0, if_pc}, 32'd0);
        check("t1_insn", if_insn, 32'hA0A0_0001);
        check("t1_addr", {2'b0, bus.fetch_addr}, 32'd1);
        // T2
        for (int i = 0; i < 4; i++) begin insn = $urandom; step("t2"); end
        check("t2_addr", {2'b0, bus.fetch_addr}, 32'd5);
        set_in(0, 1, 30'h3FFF_FFFF, 0, '0);
        step("t2_pre");
        set_in(0, 0, '0, 0, '0);
        step("t2_wrap");
        check("t2_wrap_addr", {2'b0, bus.fetch_addr}, 32'd0);
        // T3
        insn = 32'hDEAD_0003;
        set_in(0, 0, '0, 1, 30'h100);
        step("t3");
        check("t3_addr", {2'b0, bus.fetch_addr}, 32'h100);
        check("t3_slot", if_insn, 32'hDEAD_0003);
        // T4
        set_in(1, 0, '0, 1, 30'h40); step("t4a");
        set_in(1, 0, '0, 1, 30'h80); step("t4b");
        set_in(1, 0, '0, 0, '0);     step("t4c");
        check("t4_frozen", {2'b0, bus.fetch_addr}, 32'h100);
        set_in(0, 0, '0, 0, '0);     step("t4d");
        check("t4_redir", {2'b0, bus.fetch_addr}, 32'h80);
        step("t4e");
        check("t4_noreplay", {2'b0, bus.fetch_addr}, 32'h81);
        // T5
        set_in(1, 0, '0, 1, 30'h300); step("t5a");
        set_in(1, 1, 30'h20, 1, 30'h200); step("t5b");
        check("t5_addr", {2'b0, bus.fetch_addr}, 32'h20);
        check("t5_en", {31'b0, if_en}, 32'd0);
        set_in(0, 0, '0, 0, '0); step("t5c");
        check("t5_nopend", {2'b0, bus.fetch_addr}, 32'h21);
        // reset mid-stall discards the pending redirect
        set_in(1, 0, '0, 1, 30'h155); step("rs");
        #2 reset_ = 0;
        model_reset();
        #1 check_all("rs_async");
        @(negedge clk);
        reset_ = 1;
        set_in(0, 0, '0, 0, '0);
        step("rs_a"); step("rs_b");
        check("rs_restart", {2'b0, bus.fetch_addr}, 32'd1);
        // T6
        do_reset();
        step("t6s");
        for (int i = 0; i < 5; i++) step("t6f");
        set_in(1, 0, '0, 0, '0); step("t6x"); step("t6y");
        check("t6_pf", perf_fetch, PERF_ON ? 32'd5 : 32'd0);
        check("t6_ps", perf_stall, PERF_ON ? 32'd2 : 32'd0);
        // random
        for (int i = 0; i < 400; i++) begin
            insn = $urandom;
            set_in($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, 30'($urandom),
                   $urandom_range(0, 4) == 0, 30'($urandom));
            step("rnd");
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
